ucsbece154a_dmem_ws: RTL and testbench

Parametrised data memory with a request/ready handshake, programmable wait states, and byte/halfword/word accesses with sign or zero extension on loads. It replaces the single-cycle word-only data memory when the core needs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics and a memory that can take more than one cycle. It sits between the datapath load/store unit and the word array, and reports bad accesses instead of silently coercing them.

---
 rtl/ucsbece154a_dmem_ws_if.sv | 26 ++
 rtl/ucsbece154a_dmem_ws.sv | 154 +++++++++++++++
 tb/tb_ucsbece154a_dmem_ws.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154a_dmem_ws_if.sv
// Request/completion bundle between the load/store unit (master) and the
// wait-state data memory (slave).
interface ucsbece154a_dmem_ws_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] a_i;
  logic [31:0] wd_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rd_o;

  // A request is taken on any rising edge where req_i && ready_o; the block
  // answers with a single-cycle done_o pulse, err_o and rd_o valid alongside it.
  modport master (
    output req_i, we_i, size_i, unsigned_i, a_i, wd_i,
    input  ready_o, done_o, err_o, rd_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, a_i, wd_i,
    output ready_o, done_o, err_o, rd_o
  );
endinterface

// File: rtl/ucsbece154a_dmem_ws.sv
// Data memory with programmable wait states and RISC-V byte/half/word access.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses.
module ucsbece154a_dmem_ws #(
  parameter int          NUM_WORDS   = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  ucsbece154a_dmem_ws_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int          ADDR_WIDTH = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN       = 32'(NUM_WORDS * 4);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, complete;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] a_q, wd_q;

  logic        done_q, err_q;
  logic [31:0] rd_q;

  logic [31:0] mem [NUM_WORDS];

  logic                  op_we, op_uns, op_err, in_range, misalign;
  logic [1:0]            op_size;
  logic [31:0]           op_a, op_wd, off, word, wdata, ld;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign accept = bus.req_i && (state_q != BUSY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d  = DONE;
            complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d  = DONE;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access completes on its accept edge, so the
  // live request is used; otherwise the captured copy is.
  assign op_we   = (state_q == BUSY) ? we_q   : bus.we_i;
  assign op_uns  = (state_q == BUSY) ? uns_q  : bus.unsigned_i;
  assign op_size = (state_q == BUSY) ? size_q : bus.size_i;
  assign op_a    = (state_q == BUSY) ? a_q    : bus.a_i;
  assign op_wd   = (state_q == BUSY) ? wd_q   : bus.wd_i;

  assign off      = op_a - BASE_ADDR;
  assign in_range = (op_a >= BASE_ADDR) && (off < SPAN);
  assign idx      = off[ADDR_WIDTH+1:2];
  assign word     = mem[idx];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = ((op_size == 2'b01) && off[0]) ||
                    ((op_size == 2'b10) && (off[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign op_err = (op_size == 2'b11) || !in_range || misalign;

  always_comb begin
    be      = 4'hF;
    wdata   = op_wd;
    ld      = word;
    ld_byte = word[{off[1:0], 3'b000} +: 8];
    ld_half = off[1] ? word[31:16] : word[15:0];
    case (op_size)
      2'b00: begin
        be    = 4'b0001 << off[1:0];
        wdata = {4{op_wd[7:0]}};
        ld    = op_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op_wd[15:0]}};
        ld    = op_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= complete;
      err_q   <= complete && op_err;
      if (complete && !op_err && !op_we) rd_q <= ld;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= bus.we_i;
      uns_q  <= bus.unsigned_i;
      size_q <= bus.size_i;
      a_q    <= bus.a_i;
      wd_q   <= bus.wd_i;
    end
  end

  // Contents are deliberately not reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && complete && !op_err && op_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign bus.ready_o = (state_q != BUSY);
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.rd_o    = rd_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_ucsbece154a_dmem_ws.sv
// Bench for ucsbece154a_dmem_ws: directed table, reset-in-flight sequence and
// random accesses checked against a byte-array reference model.
module tb_ucsbece154a_dmem_ws;
  localparam int          NW   = 16;
  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'h0;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ucsbece154a_dmem_ws_if bus ();

  ucsbece154a_dmem_ws #(
    .NUM_WORDS  (NW),
    .WAIT_STATES(WS),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_m [NW*4];
  logic [31:0] rd_m;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: little-endian byte array, accesses described as byte counts.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off, val;
    logic        err;
    int          nb, ea;
    off = a - BASE;
    nb  = 1 << size;
    err = (size == 2'b11) || (a < BASE) || (off >= 32'(NW*4));
`ifdef DMEM_MISALIGN_ERR_EN
    if (size != 2'b11 && (off % nb) != 0) err = 1'b1;
`endif
    if (!err) begin
      ea = int'(off) - (int'(off) % nb);
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[ea+i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val = val | (32'(mem_m[ea+i]) << (8*i));
        if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
        rd_m = val;
      end
    end
    exp_q.push_back(rd_m);
    exp_err_q.push_back(err);
  endtask

  // Called at a negedge; returns at the negedge of the done_o cycle so the
  // next call issues back-to-back during DONE.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int          k;
    logic [31:0] e_rd;
    logic        e_err;
    e_rd  = exp_q.pop_front();
    e_err = exp_err_q.pop_front();
    chk("ready_at_req", {31'b0, bus.ready_o}, 32'd1);
    bus.req_i      = 1'b1;
    bus.we_i       = we;
    bus.size_i     = size;
    bus.unsigned_i = uns;
    bus.a_i        = a;
    bus.wd_i       = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_i      = 1'b0;
    bus.we_i       = 1'($urandom);
    bus.size_i     = 2'($urandom);
    bus.unsigned_i = 1'($urandom);
    bus.a_i        = $urandom;
    bus.wd_i       = $urandom;
    k = 0;
    while (!bus.done_o && k < 20) begin
      chk("ready_busy", {31'b0, bus.ready_o}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(WS));
    chk("err", {31'b0, bus.err_o}, {31'b0, e_err});
    chk("rd", bus.rd_o, e_rd);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AA, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADAAEF, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        32'hFFFFFFAA, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        32'h0000_00AA, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h06, 32'h0000_8001, 32'h0000_00AA, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h06, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h06, 32'h0,        32'h0000_8001, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h8001_0000, 1'b0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h8001_0000, 1'b1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h8001_0000, 1'b1};
`ifdef DMEM_MISALIGN_ERR_EN
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h8001_0000, 1'b1};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h03, 32'h0000_007F, 32'h8001_0000, 1'b0};
`else
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0000_0000, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h03, 32'h0000_007F, 32'h0000_0000, 1'b0};
`endif
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h03, 32'h0,        32'h0000_007F, 1'b0};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h3C, 32'h0A0B0C0D, 32'h0000_007F, 1'b0};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h3E, 32'h0,        32'h0000_0A0B, 1'b0};
    tbl[17] = '{1'b1, 2'd0, 1'b0, 32'h44, 32'h0000_0055, 32'h0000_0A0B, 1'b1};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h0A0B0C0D, 1'b0};
    tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h8001_0000, 1'b0};

    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'd0; bus.unsigned_i = 1'b0;
    bus.a_i = 32'h0; bus.wd_i = 32'h0;
    rd_m  = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", {31'b0, bus.ready_o}, 32'd1);
    chk("rst_done",  {31'b0, bus.done_o},  32'd0);
    chk("rst_err",   {31'b0, bus.err_o},   32'd0);
    chk("rst_rd",    bus.rd_o,             32'h0);
    chk("rst_state", {30'b0, state_dbg},   32'd0);

    // Known contents before anything reads back.
    for (int w = 0; w < NW; w++) begin
      model(1'b1, 2'd2, 1'b0, BASE + 32'(w*4), 32'h0);
      access(1'b1, 2'd2, 1'b0, BASE + 32'(w*4), 32'h0);
    end

    for (int i = 0; i < 20; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].a, tbl[i].wd);
      void'(exp_q.pop_back());
      void'(exp_err_q.pop_back());
      exp_q.push_back(tbl[i].exp_rd);
      exp_err_q.push_back(tbl[i].exp_err);
      access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].a, tbl[i].wd);
    end

    // Reset while a store is in flight: it must vanish without writing.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd2; bus.unsigned_i = 1'b0;
    bus.a_i = 32'h0; bus.wd_i = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_m  = 32'h0;
    chk("rst_busy_state", {30'b0, state_dbg}, 32'd0);
    chk("rst_busy_ready", {31'b0, bus.ready_o}, 32'd1);
    chk("rst_busy_rd", bus.rd_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy_done", {31'b0, bus.done_o}, 32'd0);
      @(negedge clk);
    end
    model(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] a, wd;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a    = ($urandom_range(0, 15) == 0) ? $urandom : BASE + 32'($urandom_range(0, NW*4 + 7));
      wd   = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("done_pulse", {31'b0, bus.done_o}, 32'd0);
      end
      model(we, size, uns, a, wd);
      access(we, size, uns, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
